// File: rtl/data_ram_periph_pkg.sv
// Shared definitions for the data-RAM peripheral: register offsets and helpers
// used by the register file and the display scanner.
package data_ram_periph_pkg;

  localparam logic [15:0] SCRATCH0_OFF  = 16'h0000;
  localparam logic [15:0] SCRATCH1_OFF  = 16'h0004;
  localparam logic [15:0] TIMER_OFF     = 16'hE000;
  localparam logic [15:0] LED_OFF       = 16'hF000;
  localparam logic [15:0] NUM_OFF       = 16'hF010;
  localparam logic [15:0] SWITCH_OFF    = 16'hF020;
  localparam logic [15:0] SIMU_FLAG_OFF = 16'hF030;

  // Segment order is {g,f,e,d,c,b,a}, active-high.
  function automatic logic [6:0] hex7seg(input logic [3:0] h);
    logic [6:0] s;
    case (h)
      4'h0: s = 7'h3F;  4'h1: s = 7'h06;  4'h2: s = 7'h5B;  4'h3: s = 7'h4F;
      4'h4: s = 7'h66;  4'h5: s = 7'h6D;  4'h6: s = 7'h7D;  4'h7: s = 7'h07;
      4'h8: s = 7'h7F;  4'h9: s = 7'h6F;  4'hA: s = 7'h77;  4'hB: s = 7'h7C;
      4'hC: s = 7'h39;  4'hD: s = 7'h5E;  4'hE: s = 7'h79;  default: s = 7'h71;
    endcase
    return s;
  endfunction

  function automatic logic [31:0] byte_merge(input logic [31:0] old_v,
                                             input logic [31:0] wdata,
                                             input logic [3:0]  wen);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) begin
      r[8*i +: 8] = wen[i] ? wdata[8*i +: 8] : old_v[8*i +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/data_ram_periph_seg7_scan.sv
// Scanned 8-digit 7-segment driver: one digit slot every SCAN_DIV cycles,
// registered active-low digit select and active-high segments.
module seg7_scan
  import data_ram_periph_pkg::*;
#(
  parameter int SCAN_DIV = 1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] num_i,
  output logic [7:0]  an_o,
  output logic [6:0]  seg_o
);

  localparam int CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

  logic [CW-1:0] div_q, div_d;
  logic [2:0]    dig_q, dig_d;
  logic [7:0]    an_q;
  logic [6:0]    seg_q;
  logic          tc;

  always_comb begin
    tc    = (div_q == CW'(SCAN_DIV - 1));
    div_d = tc ? '0 : div_q + 1'b1;
    dig_d = tc ? dig_q + 3'd1 : dig_q;
  end

  // Segments track NUM every cycle so a NUM write shows on the current digit next cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_q <= '0;
      dig_q <= 3'd0;
      an_q  <= 8'hFE;
      seg_q <= 7'h3F;
    end else begin
      div_q <= div_d;
      dig_q <= dig_d;
      an_q  <= ~(8'b1 << dig_d);
      seg_q <= hex7seg(num_i[{dig_d, 2'b00} +: 4]);
    end
  end

  assign an_o  = an_q;
  assign seg_o = seg_q;

endmodule

// File: rtl/data_ram_periph.sv
// Memory-mapped responder on the CPU data-RAM port: scratch, LED, NUM display,
// switch input, free-running timer and simulation flag, 1-cycle read latency.
module data_ram_periph
  import data_ram_periph_pkg::*;
#(
  parameter int SCAN_DIV = 1000,
  parameter bit SIMU     = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        data_ram_en,
  input  logic [3:0]  data_ram_w_en_4bit,
  input  logic [31:0] data_ram_addr,
  input  logic [31:0] data_ram_w_data,
  output logic [31:0] data_ram_r_data,
  input  logic [7:0]  switch,
  output logic [15:0] led,
  output logic [7:0]  num_an,
  output logic [6:0]  num_seg
);

  logic [31:0] scratch0_q, scratch0_d, scratch1_q, scratch1_d;
  logic [31:0] timer_q, timer_d, num_q, num_d, rdata_q, rdata_d;
  logic [15:0] led_q, led_d;
  logic [7:0]  sw_meta_q, sw_sync_q;
  logic [15:0] off;
  logic        wr;
  logic        addr_unused;

  assign off         = {data_ram_addr[15:2], 2'b00};
  assign addr_unused = ^{data_ram_addr[31:16], data_ram_addr[1:0]};
  assign wr          = data_ram_en && (data_ram_w_en_4bit != 4'b0000);

  always_comb begin
    scratch0_d = scratch0_q;
    scratch1_d = scratch1_q;
    timer_d    = timer_q + 32'd1;
    led_d      = led_q;
    num_d      = num_q;
    if (wr) begin
      case (off)
        SCRATCH0_OFF: scratch0_d = byte_merge(scratch0_q, data_ram_w_data, data_ram_w_en_4bit);
        SCRATCH1_OFF: scratch1_d = byte_merge(scratch1_q, data_ram_w_data, data_ram_w_en_4bit);
        TIMER_OFF:    timer_d    = byte_merge(timer_q, data_ram_w_data, data_ram_w_en_4bit);
        NUM_OFF:      num_d      = byte_merge(num_q, data_ram_w_data, data_ram_w_en_4bit);
        LED_OFF: begin
          led_d[15:8] = data_ram_w_en_4bit[1] ? data_ram_w_data[15:8] : led_q[15:8];
          led_d[7:0]  = data_ram_w_en_4bit[0] ? data_ram_w_data[7:0]  : led_q[7:0];
        end
        default: ;
      endcase
    end
  end

  // Read mux sees pre-edge register values, giving read-before-write.
  always_comb begin
    rdata_d = rdata_q;
    if (data_ram_en) begin
      case (off)
        SCRATCH0_OFF:  rdata_d = scratch0_q;
        SCRATCH1_OFF:  rdata_d = scratch1_q;
        TIMER_OFF:     rdata_d = timer_q;
        LED_OFF:       rdata_d = {16'h0000, led_q};
        NUM_OFF:       rdata_d = num_q;
        SWITCH_OFF:    rdata_d = {24'h000000, sw_sync_q};
        SIMU_FLAG_OFF: rdata_d = {31'd0, SIMU};
        default:       rdata_d = 32'd0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scratch0_q <= '0;
      scratch1_q <= '0;
      timer_q    <= '0;
      led_q      <= '0;
      num_q      <= '0;
      rdata_q    <= '0;
      sw_meta_q  <= '0;
      sw_sync_q  <= '0;
    end else begin
      scratch0_q <= scratch0_d;
      scratch1_q <= scratch1_d;
      timer_q    <= timer_d;
      led_q      <= led_d;
      num_q      <= num_d;
      rdata_q    <= rdata_d;
      sw_meta_q  <= switch;
      sw_sync_q  <= sw_meta_q;
    end
  end

  seg7_scan #(.SCAN_DIV(SCAN_DIV)) u_scan (
    .clk   (clk),
    .reset (reset),
    .num_i (num_q),
    .an_o  (num_an),
    .seg_o (num_seg)
  );

  assign data_ram_r_data = rdata_q;
  assign led             = led_q;

endmodule

// File: tb/tb_data_ram_periph.sv
// Directed bench for data_ram_periph with a read-data scoreboard.
module tb_data_ram_periph;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic [3:0]  wen;
  logic [31:0] addr, wdata;
  logic [31:0] r_data;
  logic [7:0]  sw;
  logic [15:0] led;
  logic [7:0]  num_an;
  logic [6:0]  num_seg;

  typedef struct {
    logic [31:0] d;
    bit          care;
  } exp_t;

  exp_t        sb[$];
  int          n_vec  = 0;
  int          n_fail = 0;
  logic [31:0] last_d = 32'd0;
  bit          last_care = 1'b1;

  logic [6:0] glyph [0:15] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  always #5 clk = ~clk;

  data_ram_periph #(.SCAN_DIV(4), .SIMU(1'b1)) dut (
    .clk                (clk),
    .reset              (reset),
    .data_ram_en        (en),
    .data_ram_w_en_4bit (wen),
    .data_ram_addr      (addr),
    .data_ram_w_data    (wdata),
    .data_ram_r_data    (r_data),
    .switch             (sw),
    .led                (led),
    .num_an             (num_an),
    .num_seg            (num_seg)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One bus cycle; every enabled request returns read data one edge later.
  task automatic xfer(input string tag, input logic e, input logic [3:0] we,
                      input logic [15:0] a, input logic [31:0] wd,
                      input logic [31:0] exp, input bit care);
    exp_t x;
    @(negedge clk);
    en = e; wen = we; addr = {16'h0000, a}; wdata = wd;
    if (e) sb.push_back('{d: exp, care: care});
    @(posedge clk);
    #1;
    en = 1'b0; wen = 4'h0;
    if (e) begin
      x = sb.pop_front();
      last_d = x.d; last_care = x.care;
      if (x.care) chk(tag, r_data, x.d);
    end else if (last_care) begin
      chk({tag, "_hold"}, r_data, last_d);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) xfer("idle", 1'b0, 4'h0, 16'h0, 32'h0, 32'h0, 1'b0);
  endtask

  initial begin
    exp_t x;
    bit   found;
    reset = 1'b1; en = 1'b0; wen = 4'h0; addr = '0; wdata = '0; sw = 8'h00;
    #12;
    chk("rst_an", {24'h0, num_an}, 32'hFE);
    chk("rst_seg", {25'h0, num_seg}, 32'h3F);
    chk("rst_led", {16'h0, led}, 32'h0);
    chk("rst_rdata", r_data, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    // Scratch registers and byte enables
    xfer("s0_wr", 1'b1, 4'hF, 16'h0000, 32'hDEADBEEF, 32'h0, 1'b1);
    xfer("s0_rd", 1'b1, 4'h0, 16'h0000, 32'h0, 32'hDEADBEEF, 1'b1);
    xfer("s0_wr2", 1'b1, 4'h2, 16'h0000, 32'h00001200, 32'hDEADBEEF, 1'b1);
    xfer("s0_rd2", 1'b1, 4'h0, 16'h0000, 32'h0, 32'hDEAD12EF, 1'b1);
    xfer("s1_wr", 1'b1, 4'hF, 16'h0004, 32'h12345678, 32'h0, 1'b1);
    xfer("s1_rd", 1'b1, 4'h0, 16'h0004, 32'h0, 32'h12345678, 1'b1);
    xfer("s0_rd3", 1'b1, 4'h0, 16'h0000, 32'h0, 32'hDEAD12EF, 1'b1);
    xfer("idle", 1'b0, 4'h0, 16'h0, 32'h0, 32'h0, 1'b0);

    // Timer: loaded value counts once per edge after the write edge
    xfer("tmr_wr", 1'b1, 4'hF, 16'hE000, 32'h00000010, 32'h0, 1'b0);
    idle(6);
    xfer("tmr_rd", 1'b1, 4'h0, 16'hE000, 32'h0, 32'h00000016, 1'b1);
    xfer("tmr_wr2", 1'b1, 4'hF, 16'hE000, 32'hFFFFFFFE, 32'h0, 1'b0);
    idle(2);
    xfer("tmr_wrap", 1'b1, 4'h0, 16'hE000, 32'h0, 32'h00000000, 1'b1);

    // LED read-before-write and upper-half write ignored
    xfer("led_rbw", 1'b1, 4'h3, 16'hF000, 32'h0000A5A5, 32'h0, 1'b1);
    chk("led_pin", {16'h0, led}, 32'h0000A5A5);
    xfer("led_rd", 1'b1, 4'h0, 16'hF000, 32'h0, 32'h0000A5A5, 1'b1);
    xfer("led_hi", 1'b1, 4'hC, 16'hF000, 32'hFFFF0000, 32'h0000A5A5, 1'b1);
    xfer("led_rd2", 1'b1, 4'h0, 16'hF000, 32'h0, 32'h0000A5A5, 1'b1);

    // Display scan
    xfer("num_wr", 1'b1, 4'hF, 16'hF010, 32'h76543210, 32'h0, 1'b1);
    xfer("num_rd", 1'b1, 4'h0, 16'hF010, 32'h0, 32'h76543210, 1'b1);
    idle(4);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(posedge clk); #1;
      if (num_an == 8'hFD) found = 1'b1;
    end
    chk("scan_sync", {24'h0, num_an}, 32'hFD);
    for (int k = 1; k <= 8; k++) begin
      chk("scan_an", {24'h0, num_an}, {24'h0, ~(8'b1 << (k % 8))});
      chk("scan_seg", {25'h0, num_seg}, {25'h0, glyph[k % 8]});
      repeat (3) @(posedge clk);
      #1;
      chk("scan_an_hold", {24'h0, num_an}, {24'h0, ~(8'b1 << (k % 8))});
      @(posedge clk); #1;
    end

    // RO / unmapped / switch
    xfer("simu", 1'b1, 4'h0, 16'hF030, 32'h0, 32'h00000001, 1'b1);
    xfer("unm_wr", 1'b1, 4'hF, 16'h1234, 32'hFFFFFFFF, 32'h0, 1'b1);
    xfer("unm_rd", 1'b1, 4'h0, 16'h1234, 32'h0, 32'h0, 1'b1);
    sw = 8'h5A;
    xfer("sw_wr", 1'b1, 4'hF, 16'hF020, 32'hFFFFFFFF, 32'h0, 1'b0);
    idle(3);
    xfer("sw_rd", 1'b1, 4'h0, 16'hF020, 32'h0, 32'h0000005A, 1'b1);
    xfer("simu_wr", 1'b1, 4'hF, 16'hF030, 32'h0, 32'h00000001, 1'b1);
    xfer("simu_rd", 1'b1, 4'h0, 16'hF030, 32'h0, 32'h00000001, 1'b1);

    // Asynchronous reset mid-scan / mid-count
    xfer("s0_pre", 1'b1, 4'h0, 16'h0000, 32'h0, 32'hDEAD12EF, 1'b1);
    idle(5);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("arst_an", {24'h0, num_an}, 32'hFE);
    chk("arst_seg", {25'h0, num_seg}, 32'h3F);
    chk("arst_led", {16'h0, led}, 32'h0);
    chk("arst_rdata", r_data, 32'h0);
    @(negedge clk);
    reset = 1'b0; en = 1'b1; wen = 4'h0; addr = 32'h0000E000;
    sb.push_back('{d: 32'h0, care: 1'b1});
    @(posedge clk); #1;
    en = 1'b0;
    x = sb.pop_front();
    last_d = x.d; last_care = x.care;
    chk("post_tmr", r_data, x.d);
    chk("post_an", {24'h0, num_an}, 32'hFE);
    xfer("post_s0", 1'b1, 4'h0, 16'h0000, 32'h0, 32'h0, 1'b1);
    xfer("post_num", 1'b1, 4'h0, 16'hF010, 32'h0, 32'h0, 1'b1);
    xfer("post_led", 1'b1, 4'h0, 16'hF000, 32'h0, 32'h0, 1'b1);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
